// File: rtl/run_monitor.sv
// run_monitor: watches a simple in-order core, counts activity and a writeback
// checksum, and stops on a halt instruction (after a drain window) or a timeout.
module run_monitor #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] HALT_INSTR   = XLEN'(32'h0000_006f),
  parameter int unsigned     DRAIN_CYCLES = 6,
  parameter int unsigned     MAX_CYCLES   = 200,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_instr,
  input  logic             pc_write,
  input  logic             hazard_flush,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wdata,
  output logic [1:0]       state,
  output logic             done,
  output logic             timeout,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [XLEN-1:0]  signature
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [XLEN-1:0]    halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]   wb_count_q, wb_count_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;
  logic [XLEN-1:0]    signature_q, signature_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               active;
  logic               halt_det;
  logic               last_cycle;

  // Next-state, counter and checksum logic; everything holds outside RUN/DRAIN.
  always_comb begin
    state_d       = state_q;
    halt_pc_d     = halt_pc_q;
    cycle_count_d = cycle_count_q;
    wb_count_d    = wb_count_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    signature_d   = signature_q;
    drain_d       = drain_q;

    active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    halt_det   = (if_instr == HALT_INSTR);
    // Compare in a wide domain so a saturated counter can never alias MAX_CYCLES.
    last_cycle = ((64'(cycle_count_q) + 64'd1) == 64'(MAX_CYCLES));

    if (active) begin
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
      if (wb_regwrite && (wb_rd != 5'd0)) begin
        if (wb_count_q != '1) wb_count_d = wb_count_q + CNT_W'(1);
        signature_d = {signature_q[XLEN-2:0], signature_q[XLEN-1]} ^ wb_wdata ^ XLEN'(wb_rd);
      end
      if (!pc_write && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
      if (hazard_flush && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (halt_det) begin
          halt_pc_d = if_pc;
          drain_d   = DRN_W'(DRAIN_CYCLES);
          state_d   = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else if (last_cycle) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRN_W'(1);
        if (drain_q == DRN_W'(1)) state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase

    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      halt_pc_q     <= '0;
      cycle_count_q <= '0;
      wb_count_q    <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
      signature_q   <= '0;
      drain_q       <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      halt_pc_q     <= halt_pc_d;
      cycle_count_q <= cycle_count_d;
      wb_count_q    <= wb_count_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
      signature_q   <= signature_d;
      drain_q       <= drain_d;
    end
  end

  assign state       = state_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cycle_count_q;
  assign wb_count    = wb_count_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
  assign signature   = signature_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: instance a uses defaults, instance b has no
// drain window and a 4-bit counter width to exercise saturation.
module tb_run_monitor;

  localparam logic [31:0] HALT = 32'h0000_006f;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_instr, wb_wdata;
  logic        pc_write, hazard_flush, wb_regwrite;
  logic [4:0]  wb_rd;

  logic [1:0]  a_state, b_state;
  logic        a_done, a_timeout, b_done, b_timeout;
  logic [31:0] a_halt_pc, a_sig, b_halt_pc, b_sig;
  logic [15:0] a_cyc, a_wb, a_stall, a_flush;
  logic [3:0]  b_cyc, b_wb, b_stall, b_flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  run_monitor u_a (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .pc_write(pc_write), .hazard_flush(hazard_flush), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .state(a_state), .done(a_done),
    .timeout(a_timeout), .halt_pc(a_halt_pc), .cycle_count(a_cyc),
    .wb_count(a_wb), .stall_count(a_stall), .flush_count(a_flush), .signature(a_sig)
  );

  run_monitor #(.DRAIN_CYCLES(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .pc_write(pc_write), .hazard_flush(hazard_flush), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .state(b_state), .done(b_done),
    .timeout(b_timeout), .halt_pc(b_halt_pc), .cycle_count(b_cyc),
    .wb_count(b_wb), .stall_count(b_stall), .flush_count(b_flush), .signature(b_sig)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pw;
    logic        fl;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [1:0]  e_state;
    logic [15:0] e_cyc;
    logic [15:0] e_wb;
    logic [15:0] e_stall;
    logic [15:0] e_flush;
    logic [31:0] e_sig;
    logic [31:0] e_hpc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic pw,
                       input logic fl, input logic rw, input logic [4:0] rd,
                       input logic [31:0] wd);
    if_pc = pc; if_instr = instr; pc_write = pw; hazard_flush = fl;
    wb_regwrite = rw; wb_rd = rd; wb_wdata = wd;
  endtask

  // One clock edge, then settle before any sampling.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic nop_edge;
    drive(32'h0, NOP, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    nop_edge();
    reset = 1'b0;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_state"}, a_state, 2'd0);
    chk({tag, "_flags"}, {a_done, a_timeout}, 2'b00);
    chk({tag, "_cnts"}, {a_cyc, a_wb, a_stall, a_flush}, 64'h0);
    chk({tag, "_sig_hpc"}, {a_sig, a_halt_pc}, 64'h0);
  endtask

  initial begin
    // pc instr pw fl rw rd wd | state cyc wb stall flush sig hpc
    vecs[0]  = '{32'h00, NOP,  1, 0, 1, 5'd1,  32'h5,         0, 1,  1, 0, 0, 32'h4,         32'h0};
    vecs[1]  = '{32'h04, NOP,  0, 0, 1, 5'd0,  32'h9,         0, 2,  1, 1, 0, 32'h4,         32'h0};
    vecs[2]  = '{32'h08, NOP,  1, 1, 1, 5'd2,  32'hA,         0, 3,  2, 1, 1, 32'h0,         32'h0};
    vecs[3]  = '{32'h0c, NOP,  0, 1, 0, 5'd3,  32'hFF,        0, 4,  2, 2, 2, 32'h0,         32'h0};
    vecs[4]  = '{32'h10, NOP,  1, 0, 1, 5'd31, 32'h8000_0000, 0, 5,  3, 2, 2, 32'h8000_001F, 32'h0};
    vecs[5]  = '{32'h14, NOP,  1, 0, 1, 5'd1,  32'h0,         0, 6,  4, 2, 2, 32'h3E,        32'h0};
    vecs[6]  = '{32'h100, HALT, 1, 0, 0, 5'd0, 32'h0,         1, 7,  4, 2, 2, 32'h3E,        32'h100};
    vecs[7]  = '{32'h200, HALT, 0, 0, 0, 5'd0, 32'h0,         1, 8,  4, 3, 2, 32'h3E,        32'h100};
    vecs[8]  = '{32'h00, NOP,  1, 0, 0, 5'd0,  32'h0,         1, 9,  4, 3, 2, 32'h3E,        32'h100};
    vecs[9]  = '{32'h00, NOP,  1, 0, 0, 5'd0,  32'h0,         1, 10, 4, 3, 2, 32'h3E,        32'h100};
    vecs[10] = '{32'h00, NOP,  1, 0, 0, 5'd0,  32'h0,         1, 11, 4, 3, 2, 32'h3E,        32'h100};
    vecs[11] = '{32'h00, NOP,  1, 0, 0, 5'd0,  32'h0,         1, 12, 4, 3, 2, 32'h3E,        32'h100};
    vecs[12] = '{32'h00, NOP,  1, 0, 0, 5'd0,  32'h0,         2, 13, 4, 3, 2, 32'h3E,        32'h100};
    vecs[13] = '{32'h300, HALT, 0, 1, 1, 5'd5, 32'hFFFF,      2, 13, 4, 3, 2, 32'h3E,        32'h100};

    reset = 1'b0;
    drive(32'h0, NOP, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    do_reset();
    chk_a_zero("reset");
    chk("reset_b", {b_state, b_cyc, b_wb}, 0);

    // Table: writes, x0 filter, stall/flush, halt, drain, terminal freeze.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pc, vecs[i].instr, vecs[i].pw, vecs[i].fl, vecs[i].rw, vecs[i].rd, vecs[i].wd);
      step();
      chk($sformatf("vec%0d_state", i), a_state, vecs[i].e_state);
      chk($sformatf("vec%0d_done", i), a_done, vecs[i].e_state == 2'd2);
      chk($sformatf("vec%0d_cnts", i), {a_cyc, a_wb, a_stall, a_flush},
          {vecs[i].e_cyc, vecs[i].e_wb, vecs[i].e_stall, vecs[i].e_flush});
      chk($sformatf("vec%0d_sig", i), a_sig, vecs[i].e_sig);
      chk($sformatf("vec%0d_hpc", i), a_halt_pc, vecs[i].e_hpc);
    end

    // Halt at edge 10: a drains edges 11..16; b finishes immediately.
    do_reset();
    for (int i = 1; i <= 9; i++) nop_edge();
    drive(32'hABC, HALT, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("h10_b_state", b_state, 2'd2);
    chk("h10_b_cyc", b_cyc, 4'd10);
    chk("h10_b_hpc", b_halt_pc, 32'hABC);
    for (int e = 11; e <= 16; e++) begin
      chk($sformatf("h10_pre%0d_state", e), a_state, 2'd1);
      nop_edge();
    end
    chk("h10_state", a_state, 2'd2);
    chk("h10_done", a_done, 1'b1);
    chk("h10_cyc", a_cyc, 16'd16);
    chk("h10_hpc", a_halt_pc, 32'hABC);

    // Timeout after edge 200, then frozen; b saturates at 15 and never times out.
    do_reset();
    for (int i = 1; i <= 199; i++) nop_edge();
    chk("to199_state", a_state, 2'd0);
    nop_edge();
    chk("to200_state", a_state, 2'd3);
    chk("to200_flags", {a_done, a_timeout}, 2'b01);
    chk("to200_cyc", a_cyc, 16'd200);
    chk("sat_b_cyc", b_cyc, 4'hF);
    chk("sat_b_state", b_state, 2'd0);
    for (int i = 0; i < 50; i++) begin
      drive(32'h44, HALT, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1234);
      step();
    end
    chk("tofrz_state", a_state, 2'd3);
    chk("tofrz_cnts", {a_cyc, a_wb, a_stall, a_flush}, {16'd200, 16'd0, 16'd0, 16'd0});
    chk("tofrz_sig_hpc", {a_sig, a_halt_pc}, 64'h0);

    // Halt and timeout coincide on edge 200: halt wins.
    do_reset();
    for (int i = 1; i <= 199; i++) nop_edge();
    drive(32'h800, HALT, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("coin_state", a_state, 2'd1);
    chk("coin_timeout", a_timeout, 1'b0);
    chk("coin_hpc", a_halt_pc, 32'h800);

    // Zero drain window: halt at edge 3 goes straight to DONE.
    do_reset();
    nop_edge();
    nop_edge();
    drive(32'h30, HALT, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("d0_state", b_state, 2'd2);
    chk("d0_done", b_done, 1'b1);
    chk("d0_cyc", b_cyc, 4'd3);
    nop_edge();
    chk("d0_frz_cyc", b_cyc, 4'd3);

    // Reset on the third drain edge, then identical rerun to completion.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      drive(32'h0, NOP, 1'b0, 1'b0, 1'b1, 5'd1, 32'h5);
      step();
      drive(32'h4, NOP, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      step();
      nop_edge();
      nop_edge();
      drive(32'h40, HALT, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      if (pass == 0) begin
        nop_edge();
        nop_edge();
        chk("rd_mid_state", a_state, 2'd1);
        reset = 1'b1;
        nop_edge();
        reset = 1'b0;
        chk_a_zero("rd_reset");
      end else begin
        for (int i = 0; i < 6; i++) nop_edge();
        chk("rr_state", a_state, 2'd2);
        chk("rr_cnts", {a_cyc, a_wb, a_stall, a_flush}, {16'd11, 16'd1, 16'd1, 16'd1});
        chk("rr_sig", a_sig, 32'h4);
        chk("rr_hpc", a_halt_pc, 32'h40);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- XLEN, 32, instruction/data width
- HALT_INSTR, 32'h0000_006f, halt encoding (jal x0,0)
- DRAIN_CYCLES, 6, cycles run after halt detect; 0 legal
- MAX_CYCLES, 200, timeout bound; must be ≥1
- CNT_W, 16, counter width
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- reset, in, 1, synchronous, active-high
- if_pc, in, XLEN, fetch PC
- if_instr, in, XLEN, fetch instruction
- pc_write, in, 1, 0 = front-end stall this cycle
- hazard_flush, in, 1, 1 = flush this cycle
- wb_regwrite, in, 1, writeback enable
- wb_rd, in, 5, writeback register
- wb_wdata, in, XLEN, writeback data
- state, out, 2, RUN=0, DRAIN=1, DONE=2, TIMEOUT=3
- done, out, 1, state==DONE
- timeout, out, 1, state==TIMEOUT
- halt_pc, out, XLEN, if_pc captured at halt detect
- cycle_count, out, CNT_W, active cycles
- wb_count, out, CNT_W, retired register writes
- stall_count, out, CNT_W, pc_write==0 cycles
- flush_count, out, CNT_W, hazard_flush==1 cycles
- signature, out, XLEN, writeback checksum

Function
REQ-003 An edge is active when state is RUN or DRAIN; all counters and the signature SHALL update only on active edges and SHALL freeze in DONE/TIMEOUT.
REQ-004 cycle_count SHALL increment by 1 on every active edge and SHALL saturate at 2^CNT_W-1.
REQ-005 wb_count SHALL increment (saturating) on an active edge when wb_regwrite=1 and wb_rd≠0; writes to x0 SHALL be ignored.
REQ-006 On each counted write, signature SHALL become {signature[XLEN-2:0],signature[XLEN-1]} XOR wb_wdata XOR zero-extended wb_rd.
REQ-007 stall_count and flush_count SHALL increment (saturating) on active edges when pc_write=0 or hazard_flush=1 respectively; both MAY increment on the same edge.
REQ-008 RUN→DRAIN on an edge where if_instr==HALT_INSTR; halt_pc SHALL capture if_pc on that edge; drain counter SHALL load DRAIN_CYCLES.
REQ-009 If DRAIN_CYCLES=0, halt detect SHALL go RUN→DONE directly.
REQ-010 In DRAIN, the drain counter SHALL decrement each edge; when it equals 1 the next state SHALL be DONE, so DRAIN lasts exactly DRAIN_CYCLES edges.
REQ-011 RUN→TIMEOUT on an edge where cycle_count+1==MAX_CYCLES and no halt is detected; halt detection SHALL take priority on the same edge.
REQ-012 Timeout SHALL NOT be evaluated in DRAIN; HALT_INSTR in DRAIN SHALL NOT recapture halt_pc or reload the drain counter.
REQ-013 DONE and TIMEOUT SHALL be terminal until reset; all inputs SHALL be ignored there.
REQ-014 done and timeout SHALL be decoded from the registered state, with no combinational path from inputs.

Reset
REQ-015 When reset=1 at an edge: state=RUN; all counters, signature, halt_pc and drain counter=0; done=timeout=0.
REQ-016 Reset SHALL take priority in every state, including mid-DRAIN; the reset edge itself SHALL NOT be counted.

Verification
REQ-017 Halt at 10th active edge, DRAIN_CYCLES=6 → state=DRAIN for edges 10..15, DONE after edge 16, cycle_count=16, halt_pc=PC presented at edge 10.
REQ-018 No halt, MAX_CYCLES=200 → TIMEOUT after edge 200, cycle_count=200; counters frozen for the next 50 edges.
REQ-019 Writes x1=0x5, x0=0x9, x2=0xA on three edges → wb_count=2, signature=((0x5^0x1) rotl 1)^0xA^0x2=0x00000000.
REQ-020 Halt and timeout on the same edge (edge 200) → DRAIN, not TIMEOUT.
REQ-021 DRAIN_CYCLES=0, halt at edge 3 → DONE after edge 3, cycle_count=3.
REQ-022 Reset asserted at 3rd DRAIN edge → all outputs 0 and state=RUN next cycle; re-run reaches DONE with identical counts.
